// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the six-digit multiplexed seven-segment display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_scan_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entry n holds the segment pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000,
    7'b0000000,
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  localparam logic [2:0] IDX_S0 = 3'd0;
  localparam logic [2:0] IDX_S1 = 3'd1;
  localparam logic [2:0] IDX_M0 = 3'd2;
  localparam logic [2:0] IDX_M1 = 3'd3;
  localparam logic [2:0] IDX_H0 = 3'd4;
  localparam logic [2:0] IDX_H1 = 3'd5;

endpackage

// File: rtl/seg7_scan_display_bcd.sv
// bcd_to_seg7: BCD digit to active-low seven-segment pattern.
// Ports: bcd (4-bit in), seg ({g..a} out); codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) begin
      seg = SEG_LUT[bcd];
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Scans six snapshotted BCD time digits onto a common-anode display.
// Ports: clk, rst_n, s0..h1 digits, lzb; an/seg/dp active-low outputs.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 500,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  input  logic [3:0] h0,
  input  logic [3:0] h1,
  input  logic       lzb,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [BW-1:0] B_LAST  = BW'(BLINK_DIV - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [NUM_DIGITS-1:0][3:0] snap;

  logic          slot_end;
  logic          guard;
  logic [3:0]    cur;
  logic [6:0]    dec_seg;

  logic [5:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  assign slot_end = (presc == P_LAST);
  assign guard    = (presc < P_GUARD);
  assign cur      = snap[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= IDX_S0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_H1) ? IDX_S0 : idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Capture all digits together at the frame boundary so a carry
  // rippling through the time counter never shows half-updated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
    end else if (slot_end && idx == IDX_H1) begin
      snap <= {h1, h0, m1, m0, s1, s0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bcnt == B_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  // All anodes stay off for the first GUARD cycles of each slot so the
  // previous digit's segments never ghost onto the newly selected one.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!guard) begin
      an_d  = ~(6'b000001 << idx);
      seg_d = dec_seg;
      if (idx == IDX_H1 && lzb
          && snap[IDX_H1] == 4'd0) begin
        seg_d = SEG_BLANK;
      end
      if (phase && (idx == IDX_M0
                    || idx == IDX_H0)) begin
        dp_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule
